// File: rtl/config_fsm_burst.sv
`default_nettype none
// ============================================================================
// Module      : config_fsm_burst
// Description : Configuration-stream FSM: sync detect, header decode, burst
//               frame sequencing with row select and long frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module config_fsm_burst #(
    parameter int          NUMBER_OF_ROWS     = 16,
    parameter int          ROW_SELECT_WIDTH   = 5,
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter int          DESYNC_FLAG        = 20,
    parameter int          BURST_FLAG         = 21,
    parameter logic [31:0] SYNC_PATTERN       = 32'hFAB0_FAB1,
    parameter int          STROBE_CYCLES      = 2
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic [31:0]                   WriteData,
    input  logic                          WriteStrobe,
    input  logic                          FSM_Reset,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameAddressRegister,
    output logic                          LongFrameStrobe,
    output logic [ROW_SELECT_WIDTH-1:0]   RowSelect,
    output logic                          Synced,
    output logic [15:0]                   FrameCount,
    output logic                          ConfigDone
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        HEADER = 2'd1,
        COUNT  = 2'd2,
        DATA   = 2'd3
    } state_t;

    localparam logic [ROW_SELECT_WIDTH-1:0] C_ROWS_INIT = ROW_SELECT_WIDTH'(NUMBER_OF_ROWS);
    localparam logic [ROW_SELECT_WIDTH-1:0] C_ROW_NONE  = '1;
    localparam logic [3:0]                  C_STROBE    = 4'(STROBE_CYCLES);

    state_t                          state_q, state_d;
    logic [ROW_SELECT_WIDTH-1:0]     row_cnt_q, row_cnt_d;
    logic [15:0]                     burst_left_q, burst_left_d;
    logic [FRAME_BITS_PER_ROW-1:0]   far_q, far_d;
    logic [15:0]                     frame_count_q, frame_count_d;
    logic [3:0]                      strobe_cnt_q, strobe_cnt_d;
    logic                            config_done_q, config_done_d;
    logic                            fsm_reset_q;

    logic                            w_soft_reset;
    logic                            w_frame_strobe;
    logic [FRAME_BITS_PER_ROW-1:0]   w_far_rot;

    assign w_soft_reset = FSM_Reset & ~fsm_reset_q;

    generate
        if (FRAME_BITS_PER_ROW > 1) begin : g_rot
            assign w_far_rot = {far_q[FRAME_BITS_PER_ROW-2:0], far_q[FRAME_BITS_PER_ROW-1]};
        end else begin : g_no_rot
            assign w_far_rot = far_q;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        burst_left_d   = burst_left_q;
        far_d          = far_q;
        frame_count_d  = frame_count_q;
        strobe_cnt_d   = (strobe_cnt_q != 4'd0) ? strobe_cnt_q - 4'd1 : 4'd0;
        config_done_d  = 1'b0;
        w_frame_strobe = 1'b0;

        // A soft-reset edge wins over any word presented in the same cycle.
        if (w_soft_reset) begin
            state_d      = UNSYNC;
            row_cnt_d    = '0;
            burst_left_d = 16'd0;
        end else if (WriteStrobe) begin
            case (state_q)
                UNSYNC: begin
                    if (WriteData == SYNC_PATTERN) begin
                        state_d = HEADER;
                    end
                end
                HEADER: begin
                    if (WriteData[DESYNC_FLAG]) begin
                        state_d       = UNSYNC;
                        config_done_d = 1'b1;
                    end else begin
                        far_d = WriteData[FRAME_BITS_PER_ROW-1:0];
                        if (WriteData[BURST_FLAG]) begin
                            state_d = COUNT;
                        end else begin
                            burst_left_d = 16'd1;
                            row_cnt_d    = C_ROWS_INIT;
                            state_d      = DATA;
                        end
                    end
                end
                COUNT: begin
                    burst_left_d = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
                    row_cnt_d    = C_ROWS_INIT;
                    state_d      = DATA;
                end
                DATA: begin
                    row_cnt_d = row_cnt_q - 1'b1;
                    if (row_cnt_q == ROW_SELECT_WIDTH'(1)) begin
                        w_frame_strobe = 1'b1;
                        if (burst_left_q > 16'd1) begin
                            burst_left_d = burst_left_q - 16'd1;
                            far_d        = w_far_rot;
                            row_cnt_d    = C_ROWS_INIT;
                        end else begin
                            state_d = HEADER;
                        end
                    end
                end
                default: state_d = UNSYNC;
            endcase
        end

        // A new frame restarts the long strobe even if one is still running.
        if (w_frame_strobe) begin
            strobe_cnt_d = C_STROBE;
            if (frame_count_q != 16'hFFFF) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= UNSYNC;
            row_cnt_q     <= '0;
            burst_left_q  <= 16'd0;
            far_q         <= '0;
            frame_count_q <= 16'd0;
            strobe_cnt_q  <= 4'd0;
            config_done_q <= 1'b0;
            fsm_reset_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            burst_left_q  <= burst_left_d;
            far_q         <= far_d;
            frame_count_q <= frame_count_d;
            strobe_cnt_q  <= strobe_cnt_d;
            config_done_q <= config_done_d;
            fsm_reset_q   <= FSM_Reset;
        end
    end

    assign RowSelect            = (state_q == DATA && WriteStrobe) ? row_cnt_q : C_ROW_NONE;
    assign Synced               = (state_q != UNSYNC);
    assign LongFrameStrobe      = (strobe_cnt_q != 4'd0);
    assign ConfigDone           = config_done_q;
    assign FrameCount           = frame_count_q;
    assign FrameAddressRegister = far_q;

endmodule
`default_nettype wire

// File: tb/tb_config_fsm_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_fsm_burst
// Description : Randomized self-checking bench for config_fsm_burst driven by
//               a transaction-level model of the configuration stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_fsm_burst;

    localparam int          N      = 16;
    localparam int          S      = 2;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [4:0]  NO_ROW = 5'h1F;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        FSM_Reset;
    logic [31:0] FrameAddressRegister;
    logic        LongFrameStrobe;
    logic [4:0]  RowSelect;
    logic        Synced;
    logic [15:0] FrameCount;
    logic        ConfigDone;

    config_fsm_burst dut (
        .CLK                  (CLK),
        .resetn               (resetn),
        .WriteData            (WriteData),
        .WriteStrobe          (WriteStrobe),
        .FSM_Reset            (FSM_Reset),
        .FrameAddressRegister (FrameAddressRegister),
        .LongFrameStrobe      (LongFrameStrobe),
        .RowSelect            (RowSelect),
        .Synced               (Synced),
        .FrameCount           (FrameCount),
        .ConfigDone           (ConfigDone)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;

    // Expected post-edge view of the stream, updated per transaction.
    bit          exp_synced = 1'b0;
    logic [31:0] exp_far    = '0;
    int          exp_fc     = 0;
    int          lfs_left   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return (x << 1) | (x >> 31);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic ws, input logic [31:0] d, input logic fr,
                        input logic [4:0] rs_exp, input bit done, input bit cd);
        WriteStrobe = ws;
        WriteData   = d;
        FSM_Reset   = fr;
        #1;
        check_value("RowSelect", 32'(RowSelect), 32'(rs_exp));
        @(posedge CLK);
        @(negedge CLK);
        if (done) begin
            lfs_left = S;
            if (exp_fc < 65535) exp_fc++;
        end else if (lfs_left > 0) begin
            lfs_left--;
        end
        check_value("LongFrameStrobe", 32'(LongFrameStrobe), 32'(lfs_left > 0));
        check_value("ConfigDone", 32'(ConfigDone), 32'(cd));
        check_value("Synced", 32'(Synced), 32'(exp_synced));
        check_value("FrameAddress", FrameAddressRegister, exp_far);
        check_value("FrameCount", 32'(FrameCount), 32'(exp_fc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom, 1'b0, NO_ROW, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check_value("rst LongFrameStrobe", 32'(LongFrameStrobe), 32'd0);
        check_value("rst ConfigDone", 32'(ConfigDone), 32'd0);
        check_value("rst Synced", 32'(Synced), 32'd0);
        check_value("rst RowSelect", 32'(RowSelect), 32'(NO_ROW));
        check_value("rst FrameCount", 32'(FrameCount), 32'd0);
        check_value("rst FrameAddress", FrameAddressRegister, 32'd0);
    endtask

    task automatic do_sync(input int garbage);
        logic [31:0] w;
        for (int i = 0; i < garbage; i++) begin
            w = $urandom;
            if (w == SYNC) w = w ^ 32'd1;
            tick(1'b1, w, 1'b0, NO_ROW, 1'b0, 1'b0);
        end
        exp_synced = 1'b1;
        tick(1'b1, SYNC, 1'b0, NO_ROW, 1'b0, 1'b0);
    endtask

    task automatic do_desync();
        logic [31:0] w;
        w = $urandom | 32'h0010_0000;
        exp_synced = 1'b0;
        tick(1'b1, w, 1'b0, NO_ROW, 1'b0, 1'b1);
        tick(1'b0, $urandom, 1'b0, NO_ROW, 1'b0, 1'b0);
    endtask

    // Header (+count) and all frames; optionally interrupted at a data word
    // by a soft reset edge (hard=0) or by resetn (hard=1).
    task automatic do_burst(input logic [31:0] hdr_base, input bit burst, input int cnt,
                            input int gap_pct, input int abort_idx, input bit hard);
        logic [31:0] hdr, d;
        int          nfr, idx;
        bit          last;
        hdr     = hdr_base;
        hdr[20] = 1'b0;
        hdr[21] = burst;
        exp_far = hdr;
        tick(1'b1, hdr, 1'b0, NO_ROW, 1'b0, 1'b0);
        nfr = 1;
        if (burst) begin
            tick(1'b1, {16'($urandom), 16'(cnt)}, 1'b0, NO_ROW, 1'b0, 1'b0);
            nfr = (cnt == 0) ? 1 : cnt;
        end
        idx = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < N; r++) begin
                while ($urandom_range(0, 99) < gap_pct) idle(1);
                d = ($urandom_range(0, 7) == 0) ? SYNC : $urandom;
                if (idx == abort_idx) begin
                    if (hard) begin
                        WriteStrobe = 1'b1;
                        WriteData   = d;
                        resetn      = 1'b0;
                        #1;
                        check_reset_outputs();
                        exp_fc = 0; exp_far = '0; lfs_left = 0; exp_synced = 1'b0;
                        @(posedge CLK);
                        @(negedge CLK);
                        resetn = 1'b1;
                        idle(1);
                    end else begin
                        exp_synced = 1'b0;
                        tick(1'b1, d, 1'b1, 5'(N - r), 1'b0, 1'b0);
                        idle(1);
                    end
                    return;
                end
                last = (r == N - 1);
                if (last && f < nfr - 1) exp_far = rotl1(exp_far);
                tick(1'b1, d, 1'b0, 5'(N - r), last, 1'b0);
                idx++;
            end
        end
    endtask

    initial begin
        resetn      = 1'b0;
        WriteData   = '0;
        WriteStrobe = 1'b0;
        FSM_Reset   = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_reset_outputs();
        resetn = 1'b1;
        idle(2);

        // Single frame, no burst.
        do_sync(2);
        do_burst(32'h0000_0004, 1'b0, 0, 0, -1, 1'b0);
        idle(3);

        // Three-frame burst with address rotation, straight from HEADER.
        do_burst(32'h0020_0001, 1'b1, 3, 0, -1, 1'b0);
        idle(1);

        // Burst count of zero behaves as one frame.
        do_burst(32'h1234_5678, 1'b1, 0, 0, -1, 1'b0);

        // Desync from HEADER.
        do_desync();

        // Soft reset after 7 data words, then garbage is ignored.
        do_sync(0);
        do_burst(32'h0000_00A5, 1'b0, 0, 0, 7, 1'b0);
        do_sync(4);

        // Same single frame with gaps between data words.
        do_burst(32'h0000_0004, 1'b0, 0, 50, -1, 1'b0);

        // Soft reset on the final word of a frame produces no strobe.
        do_burst(32'h0000_0011, 1'b0, 0, 0, N - 1, 1'b0);

        // Randomized transaction mix.
        for (int it = 0; it < 24; it++) begin
            if (!exp_synced) do_sync($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                do_desync();
            end else begin
                do_burst($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                         $urandom_range(0, 40),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 47) : -1, 1'b0);
            end
            idle($urandom_range(0, 2));
        end

        // Hard reset in the middle of a burst, then recovery.
        if (!exp_synced) do_sync(0);
        do_burst(32'h0000_0003, 1'b1, 3, 10, 20, 1'b1);
        do_sync(1);
        do_burst(32'h8000_0001, 1'b1, 2, 20, -1, 1'b0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
